// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Contains the Brent-Kung adder used for trial subtraction and negation.

module bk_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N:0]   sum_o
);

  // Carry-in is folded into bit 0 so the prefix tree yields every carry directly
  always_comb begin : prefix
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] x;
    x = a_i ^ b_i;
    g = a_i & b_i;
    p = x;
    g[0] = g[0] | (p[0] & cin_i);
    for (int d = 1; d < N; d = d * 2) begin
      for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    for (int d = N / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    sum_o[0] = x[0] ^ cin_i;
    for (int i = 1; i < N; i++) begin
      sum_o[i] = x[i] ^ g[i-1];
    end
    sum_o[N] = g[N-1];
  end

endmodule

module div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [2:0] {IDLE, NEGA, NEGB, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              isRem_q, isRem_d;
  logic              isSigned_q, isSigned_d;
  logic              negQuot_q, negQuot_d;
  logic              negRem_q, negRem_d;

  logic [XLEN-1:0]   shifted;
  logic [XLEN:0]     trialSum;
  logic [XLEN-1:0]   negIn;
  logic [XLEN:0]     negSum;
  logic              calcOk;
  logic              acceptSigned;

  assign shifted = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
  assign calcOk  = rem_q[XLEN-1] | trialSum[XLEN];

  bk_adder #(.N(XLEN)) uSub (
    .a_i   (shifted),
    .b_i   (~div_q),
    .cin_i (1'b1),
    .sum_o (trialSum)
  );

  // In IDLE the negator sees the incoming divisor; its carry-out flags a zero divisor
  bk_adder #(.N(XLEN)) uNeg (
    .a_i   (~negIn),
    .b_i   ('0),
    .cin_i (1'b1),
    .sum_o (negSum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      quot_q     <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      isRem_q    <= 1'b0;
      isSigned_q <= 1'b0;
      negQuot_q  <= 1'b0;
      negRem_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      isRem_q    <= isRem_d;
      isSigned_q <= isSigned_d;
      negQuot_q  <= negQuot_d;
      negRem_q   <= negRem_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    div_d        = div_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    isRem_d      = isRem_q;
    isSigned_d   = isSigned_q;
    negQuot_d    = negQuot_q;
    negRem_d     = negRem_q;
    negIn        = quot_q;
    acceptSigned = ~op_i[0];
    case (state_q)
      IDLE: begin
        negIn = divisor_i;
        if (start_i && !kill_i) begin
          quot_d     = dividend_i;
          div_d      = divisor_i;
          isRem_d    = op_i[1];
          isSigned_d = acceptSigned;
          negQuot_d  = acceptSigned & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
          negRem_d   = acceptSigned & dividend_i[XLEN-1];
          if (negSum[XLEN]) begin
            result_d = op_i[1] ? dividend_i : '1;
            state_d  = DONE;
          end else if (acceptSigned && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (&divisor_i)) begin
            result_d = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = DONE;
          end else begin
            state_d = NEGA;
          end
        end
      end
      NEGA: begin
        negIn = quot_q;
        if (isSigned_q && quot_q[XLEN-1]) quot_d = negSum[XLEN-1:0];
        state_d = NEGB;
      end
      NEGB: begin
        negIn = div_q;
        if (isSigned_q && div_q[XLEN-1]) div_d = negSum[XLEN-1:0];
        rem_d   = '0;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        rem_d  = calcOk ? trialSum[XLEN-1:0] : shifted;
        quot_d = {quot_q[XLEN-2:0], calcOk};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        negIn    = isRem_q ? rem_q : quot_q;
        result_d = (isRem_q ? negRem_q : negQuot_q) ? negSum[XLEN-1:0] : negIn;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush abandons the operation without touching the visible result
    if (kill_i && state_q != IDLE) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: results, latency, special cases,
// kill, start-while-busy and mid-operation reset.

module tb_div_unit;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div_unit #(.XLEN(32), .ITER(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .kill_i     (kill),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result)
  );

  always #5 clk = ~clk;

  // Called at a negedge in cycle T; returns just after the accepting edge
  task automatic issueStart(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat is the cycle offset from T at which done was seen, -1 on timeout
  task automatic waitDone(input int fromK, output int lat, output logic [31:0] res);
    lat = -1;
    res = 'x;
    for (int k = fromK + 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b, expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset result: got %h, expected 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [1:0]  vo [6];
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] ve [6];
    int lat;
    logic [31:0] res;
    vo = '{OP_DIVU, OP_DIVU, OP_REMU, OP_REMU, OP_DIVU, OP_REMU};
    va = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    vb = '{32'h1, 32'h80000000, 32'h80000000, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ve = '{32'hFFFFFFFF, 32'h1, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issueStart(vo[i], va[i], vb[i]);
      waitDone(0, lat, res);
      checks++; if (lat != 36) begin errors++; $display("[TB] FAIL unsigned[%0d] latency: got %0d, expected 36", i, lat); end
      checks++; if (res !== ve[i]) begin errors++; $display("[TB] FAIL unsigned[%0d] result: got %h, expected %h", i, res, ve[i]); end
    end
  endtask

  task automatic test_signed();
    logic [1:0]  vo [8];
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] ve [8];
    int lat;
    logic [31:0] res;
    vo = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REM};
    va = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFF9C, 32'hFFFFFF9C, 32'd100, 32'd100};
    vb = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9};
    ve = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'hFFFFFFFE, 32'hFFFFFFF2, 32'd2};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issueStart(vo[i], va[i], vb[i]);
      waitDone(0, lat, res);
      checks++; if (lat != 36) begin errors++; $display("[TB] FAIL signed[%0d] latency: got %0d, expected 36", i, lat); end
      checks++; if (res !== ve[i]) begin errors++; $display("[TB] FAIL signed[%0d] result: got %h, expected %h", i, res, ve[i]); end
    end
  endtask

  task automatic test_special();
    logic [1:0]  vo [6];
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] ve [6];
    int lat;
    logic [31:0] res;
    vo = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    va = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    vb = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ve = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issueStart(vo[i], va[i], vb[i]);
      waitDone(0, lat, res);
      checks++; if (lat != 1) begin errors++; $display("[TB] FAIL special[%0d] latency: got %0d, expected 1", i, lat); end
      checks++; if (res !== ve[i]) begin errors++; $display("[TB] FAIL special[%0d] result: got %h, expected %h", i, res, ve[i]); end
    end
  endtask

  task automatic test_kill();
    int lat;
    logic [31:0] res;
    logic sawDone;
    @(negedge clk);
    issueStart(OP_DIV, 32'd100, 32'd7);
    waitDone(0, lat, res);
    checks++; if (res !== 32'd14) begin errors++; $display("[TB] FAIL kill setup result: got %h, expected 0000000e", res); end
    @(negedge clk);
    issueStart(OP_DIVU, 32'd1000, 32'd10);
    sawDone = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sawDone = sawDone | done;
    end
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL kill busy: got %b, expected 0", busy); end
    checks++; if ((done | sawDone) !== 1'b0) begin errors++; $display("[TB] FAIL kill done: got %b, expected 0", done | sawDone); end
    checks++; if (result !== 32'd14) begin errors++; $display("[TB] FAIL kill result: got %h, expected 0000000e", result); end
    issueStart(OP_REM, 32'd100, 32'd7);
    waitDone(0, lat, res);
    checks++; if (lat != 36) begin errors++; $display("[TB] FAIL after-kill latency: got %0d, expected 36", lat); end
    checks++; if (res !== 32'd2) begin errors++; $display("[TB] FAIL after-kill result: got %h, expected 00000002", res); end
    // kill outranks start in IDLE
    @(negedge clk);
    kill = 1'b1;
    issueStart(OP_DIV, 32'd9, 32'd3);
    kill = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle-kill busy: got %b, expected 0", busy); end
    checks++; if (result !== 32'd2) begin errors++; $display("[TB] FAIL idle-kill result: got %h, expected 00000002", result); end
  endtask

  task automatic test_busy_start();
    int lat;
    logic [31:0] res;
    @(negedge clk);
    issueStart(OP_DIV, 32'd100, 32'd7);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    @(negedge clk);
    issueStart(OP_DIVU, 32'hFFFFFFFF, 32'd1);
    waitDone(5, lat, res);
    checks++; if (lat != 36) begin errors++; $display("[TB] FAIL busy-start latency: got %0d, expected 36", lat); end
    checks++; if (res !== 32'd14) begin errors++; $display("[TB] FAIL busy-start result: got %h, expected 0000000e", res); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] res;
    @(negedge clk);
    issueStart(OP_DIV, 32'd100, 32'd7);
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid-reset busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid-reset done: got %b, expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL mid-reset result: got %h, expected 0", result); end
    issueStart(OP_DIVU, 32'd1000, 32'd10);
    waitDone(0, lat, res);
    checks++; if (lat != 36) begin errors++; $display("[TB] FAIL post-reset latency: got %0d, expected 36", lat); end
    checks++; if (res !== 32'd100) begin errors++; $display("[TB] FAIL post-reset result: got %h, expected 00000064", res); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_kill();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
